// File: rtl/rs_flag_arbiter_pkg.sv
// rs_flag_arbiter_pkg: shared state encodings, default sizes and width helper for the RS flag arbiter
package rs_flag_arbiter_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_DRIVE = 2'd1, ST_RELEASE = 2'd2;
    localparam int N_REQ_DEF = 4;
    localparam int FLAGS_DEF = 8;
    localparam int PULSE_CYC_DEF = 2;
    function automatic int idx_width(input int n);
        int w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
    localparam int IDXW_DEF = idx_width(FLAGS_DEF);
endpackage

// File: rtl/rs_flag_cell.sv
// rs_flag_cell: single clocked RS flip-flop, S sets, R clears, both low holds
module rs_flag_cell (
    input  logic clk,
    input  logic resetn,
    input  logic S,
    input  logic R,
    output logic Q
);
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) Q <= 1'b0;
        else if (S) Q <= 1'b1;
        else if (R) Q <= 1'b0;
endmodule

// File: rtl/rs_flag_arbiter.sv
// rs_flag_arbiter: round-robin arbiter driving one RS flag cell at a time for PULSE_CYC cycles, then acknowledging
module rs_flag_arbiter
    import rs_flag_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int FLAGS = FLAGS_DEF,
    parameter int IDXW = IDXW_DEF,
    parameter int PULSE_CYC = PULSE_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      op,
    input  logic [N_REQ*IDXW-1:0] idx,
    output logic [N_REQ-1:0]      gnt,
    output logic                  err,
    output logic                  busy,
    output logic [FLAGS-1:0]      Q
);
    localparam int PW = idx_width(N_REQ);
    localparam int CW = idx_width(PULSE_CYC);
    logic [1:0] state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] ptr, win, nxt;
    logic lop, found, in_range;
    logic [IDXW-1:0] lidx;
    logic [FLAGS-1:0] sel, s, r;
    // descending scan so the nearest requester after ptr is the last one assigned
    always_comb begin
        found = 1'b0;
        nxt = ptr;
        for (int i = N_REQ; i >= 1; i--) begin
            int c;
            c = (int'(ptr) + i) % N_REQ;
            if (req[c]) begin
                found = 1'b1;
                nxt = PW'(c);
            end
        end
    end
    // S and R come from one select vector gated by op, so no cell can ever see both
    always_comb begin
        in_range = int'(lidx) < FLAGS;
        sel = (state == ST_DRIVE && in_range) ? FLAGS'(1) << lidx : '0;
        s = lop ? sel : '0;
        r = lop ? '0 : sel;
        gnt = (state == ST_RELEASE) ? N_REQ'(1) << win : '0;
        err = state == ST_RELEASE && !in_range;
        busy = state != ST_IDLE;
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state <= ST_IDLE;
            cnt <= '0;
            ptr <= PW'(N_REQ - 1);
            win <= '0;
            lop <= 1'b0;
            lidx <= '0;
        end else
            case (state)
                ST_IDLE:
                    if (found) begin
                        win <= nxt;
                        lop <= op[nxt];
                        lidx <= idx[nxt*IDXW+:IDXW];
                        cnt <= CW'(PULSE_CYC - 1);
                        state <= ST_DRIVE;
                    end
                ST_DRIVE:
                    if (cnt == '0) state <= ST_RELEASE;
                    else cnt <= cnt - 1'b1;
                ST_RELEASE: begin
                    ptr <= win;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
    for (genvar g = 0; g < FLAGS; g++) begin : g_cell
        rs_flag_cell u_cell (.clk(clk), .resetn(resetn), .S(s[g]), .R(r[g]), .Q(Q[g]));
    end
endmodule

// File: doc/rs_flag_arbiter.md
Name: rs_flag_arbiter

Overview:
- Shared controller for a bank of clocked RS flag cells.
- Accepts set/reset commands from N_REQ requesters and arbitrates them round-robin.
- Drives exactly one cell's S or R input for a programmable pulse width, then acknowledges the winner.
- Never drives R=S=1 on any cell, so the forbidden RS condition is impossible by construction.

Parameters:
- N_REQ, 4, number of requesters
- FLAGS, 8, number of RS flag cells in the bank
- IDXW, 3, width of one flag index (ceil(log2(FLAGS)))
- PULSE_CYC, 2, cycles S/R is held asserted per command (>=1)

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester command request, level, held until gnt
- op  in  N_REQ  per-requester operation: 1=set, 0=reset
- idx  in  N_REQ*IDXW  per-requester flag index; requester k uses bits [k*IDXW +: IDXW]
- gnt  out  N_REQ  one-hot, one-cycle completion pulse to the serviced requester
- err  out  1  one-cycle pulse with gnt when the serviced idx >= FLAGS
- busy  out  1  high in any state other than IDLE
- Q  out  FLAGS  current flag bank contents

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, all Q=0, gnt=0, err=0, busy=0, cnt=0.
  - Round-robin pointer ptr=N_REQ-1, so requester 0 has first priority.
  - Applies immediately mid-command; the in-flight command is dropped and never acknowledged.
- State machine IDLE -> DRIVE -> RELEASE -> IDLE.
- IDLE:
  - If any req bit is set, select the winner as the first set bit searching ptr+1, ptr+2, ... modulo N_REQ.
  - Latch winner, op[winner], idx[winner]; cnt<=PULSE_CYC-1; go to DRIVE.
  - If no req is set, stay in IDLE. Nothing is driven.
- DRIVE:
  - If latched idx < FLAGS, assert cell S (op=1) or R (op=0) for that cell only; all other cells see R=S=0.
  - Cells are clocked, so Q[idx] updates at the first edge inside DRIVE.
  - Decrement cnt; when cnt==0, go to RELEASE.
  - Duration is exactly PULSE_CYC cycles.
- RELEASE:
  - All cells R=S=0.
  - gnt[winner]=1 for this single cycle; err=1 in the same cycle if latched idx >= FLAGS (bank untouched in that case).
  - ptr<=winner; go to IDLE.
- Latency: req sampled in IDLE -> gnt asserted PULSE_CYC+1 cycles later. Min repeat interval per command is PULSE_CYC+2 cycles.
- req/op/idx are sampled only in IDLE. Changes during DRIVE/RELEASE are ignored.
  - A req dropped before gnt still completes and still receives gnt.
- A requester still holding req at its gnt cycle is eligible again, but only after all other pending requesters (round-robin fairness).
- Set on an already-set flag, or reset on a clear flag, is legal: Q unchanged, gnt still issued.
- Invariant: for every cell, S&R==0 in every cycle. At most one cell has S|R asserted in any cycle.
- gnt is one-hot or zero at all times. busy=0 exactly when state=IDLE.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE, ST_DRIVE, ST_RELEASE
  - default localparams for N_REQ, FLAGS, PULSE_CYC
  - a clog2-style helper constant for IDXW
- One sub-module, rs_flag_cell:
  - single clocked RS flip-flop with ports clk, resetn (async clear to 0), S, R, Q
  - instantiated FLAGS times by generate
  - S=1 sets, R=1 clears, both 0 holds; the controller never presents R=S=1

Test Plan:
- Reset: hold resetn=0 with req=4'b1111 -> Q=8'h00, gnt=0, busy=0. Release resetn -> first gnt goes to requester 0.
- Single set: req[2]=1, op[2]=1, idx=5, PULSE_CYC=2 -> Q[5] rises 1 cycle after sampling; gnt=4'b0100 exactly 3 cycles after sampling; Q=8'h20.
- Reset command: Q=8'h20, then req[1] with op=0, idx=5 -> Q=8'h00; gnt=4'b0010. Then a set and a reset of the same flag from two requesters -> applied in round-robin order, and the final Q matches the later one.
- Fairness: all four req held continuously with distinct idx -> gnt order 0,1,2,3,0, each separated by PULSE_CYC+2 cycles.
- Bad index: FLAGS=6, req[3] with idx=7 -> Q unchanged, gnt[3] and err pulse together. A checker flags any cycle with S&R on any cell.
- Mid-op reset: pull resetn low during DRIVE -> Q=0 immediately, no gnt, state IDLE, ptr restored to N_REQ-1.
